template_match_sad: RTL and testbench
=====================================

# template_match_sad

Parametrised SAD/SSD template matcher for the camera pipeline. Loads a T_W×T_H template from SRAM, then scans a SRCH_W×SRCH_H window of candidate positions in the frame stored in the same SRAM, one pixel read per cycle. It reports the best-matching offset and its score. Compared with the single-mode matcher, it adds:

- configurable template and search geometry;
- SAD or SSD scoring;
- optional early termination;
- an abort input;
- a busy/done handshake.

## Interface

Parameters:

- PIX_W, 8: pixel width; pixel is mem_data[PIX_W-1:0]
- DATA_W, 16: SRAM word width
- ADDR_W, 20: SRAM address width
- T_W, 8: template width, in pixels
- T_H, 8: template height, in pixels
- SRCH_W, 16: candidate positions per row
- SRCH_H, 16: candidate rows
- IMG_W, 640: frame line pitch, in words
- TPL_BASE, 20'h00000: template base address, stored row-major, pitch T_W
- IMG_BASE, 20'h10000: frame base address

Ports:

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a match; sampled only in IDLE
- abort  in  1  cancel the current match
- mode_ssd  in  1  0 = SAD, 1 = SSD; latched at start
- early_term  in  1  enable candidate early termination; latched at start
- org_x  in  ADDR_W  search-window origin column; latched at start
- org_y  in  ADDR_W  search-window origin row; latched at start
- mem_addr  out  ADDR_W  SRAM read address
- mem_rd  out  1  read strobe; data valid on mem_data in the next cycle
- mem_data  in  DATA_W  SRAM read data
- busy  out  1  high from the cycle after start until done or abort
- done  out  1  one-cycle pulse; results are valid from this cycle on
- best_x  out  $clog2(SRCH_W)  winning column offset
- best_y  out  $clog2(SRCH_H)  winning row offset
- best_score  out  ACC_W  winning score

## Operation

Definitions:

- N = T_W*T_H.
- ACC_W = 2*PIX_W + $clog2(N).
- SAD term = |t - p|. SSD term = (t - p)², unsigned.
- The accumulator never wraps.

The template (N×PIX_W) is buffered internally in registers.

State machine:

- IDLE: start=1 → latch the mode inputs and origin, → LOAD.
- LOAD: issue N reads at TPL_BASE+i, i = 0..N-1, one per cycle. Capture each pixel one cycle later. → SEARCH after the last capture.
- SEARCH: for each candidate (cx, cy), in row-major order cy-outer:
  - Issue N reads at IMG_BASE + (org_y+cy+ty)*IMG_W + (org_x+cx+tx), with tx inner.
  - Accumulate each term as its data arrives.
  - One compare cycle follows the last term.
- SEARCH → DONE after the compare for candidate (SRCH_W-1, SRCH_H-1).
- DONE: pulse done, drop busy, → IDLE.

Compare rule:

- Update the best result only if acc < best_score (strict). On ties the earliest candidate in scan order is kept.
- best_score is initialised to all-ones at start.

Early termination (early_term=1):

- When a running acc ≥ best_score, stop issuing reads for that candidate and discard the pending read's data.
- Move to the next candidate on the following cycle.
- Results must equal those of the early_term=0 run.

Other rules:

- Address arithmetic is modulo 2^ADDR_W. Out-of-frame windows are not checked; the caller guarantees legality.
- start while busy is ignored.
- abort has priority over every transition. It returns to IDLE on the next edge with no done pulse, mem_rd=0, busy=0. best_* keep their last values.
- start and abort in the same IDLE cycle: abort wins and the match does not start.

## Timing

Reset values: mem_addr=0, mem_rd=0, busy=0, done=0, best_x=0, best_y=0, best_score=0.

Cycle counting:

- start sampled high at edge k: busy=1 and the first mem_rd=1 at edge k+1.
- LOAD occupies N+1 cycles.
- Each candidate occupies N+1 cycles (N reads plus one compare; the last data cycle overlaps the compare).
- With early_term=0, done rises at edge k+1+(N+1)+C*(N+1), where C = SRCH_W*SRCH_H. With defaults, k+16706.
- mem_rd is high in exactly N*(C+1) cycles when early_term=0.

Reset and output timing:

- Asynchronous reset mid-operation forces all outputs to their reset values immediately, clears the FSM to IDLE, and loses the internal template.
- best_* update in the cycle before done and stay stable until the next start's first update.

## Test plan

Common bench parameters, unless stated otherwise: T_W=T_H=4, SRCH_W=SRCH_H=4, IMG_W=16. The SRAM model returns data one cycle after mem_rd.

- **Exact match.** Random frame; template = frame block at (2,1); org=(0,0); SAD, early_term=0.
  - Required: best_x=2, best_y=1, best_score=0.
  - Required: done exactly 1+17+16*17=290 cycles after start.
- **Tie.** Identical 4×4 blocks at (1,0) and (3,2).
  - Required: best=(1,0).
- **Early termination / SSD.** Same images run with SSD and early_term=0, then with SSD and early_term=1.
  - Required: identical best_x, best_y and best_score in both runs.
  - Required: fewer mem_rd cycles with early_term=1.
- **Saturation width.** Template all 255, frame all 0, SSD, default T=8×8.
  - Required: best_score = 64*65025 = 4161600 with no wrap.
- **Abort.** abort pulsed 50 cycles after start.
  - Required: next cycle busy=0 and mem_rd=0; no done pulse.
  - Required: a new start then completes normally.
- **Reset mid-search.** rst driven low during SEARCH.
  - Required: all outputs zero asynchronously.
  - Required: start is ignored while rst=0; a start after release completes with correct results.

Source files
------------

// File: rtl/template_match_sad.sv
// template_match_sad: SAD/SSD template matcher that scans a search window of a frame held in SRAM
// Ports: clk, rst (asynchronous, active-low); start/abort control; mode_ssd, early_term, org_x, org_y latched at start;
//        mem_addr/mem_rd/mem_data SRAM read port with one-cycle read latency;
//        busy/done handshake; best_x/best_y/best_score hold the winning offset and its score.
module template_match_sad #(
  parameter int PIX_W = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int T_W = 8,
  parameter int T_H = 8,
  parameter int SRCH_W = 16,
  parameter int SRCH_H = 16,
  parameter int IMG_W = 640,
  parameter logic [ADDR_W-1:0] TPL_BASE = '0,
  parameter logic [ADDR_W-1:0] IMG_BASE = ADDR_W'(32'h10000),
  localparam int N = T_W * T_H,
  localparam int ACC_W = 2 * PIX_W + $clog2(N),
  localparam int XW = $clog2(SRCH_W),
  localparam int YW = $clog2(SRCH_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode_ssd,
  input  logic              early_term,
  input  logic [ADDR_W-1:0] org_x,
  input  logic [ADDR_W-1:0] org_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic [XW-1:0]     best_x,
  output logic [YW-1:0]     best_y,
  output logic [ACC_W-1:0]  best_score
);
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] di;
  logic [PIX_W-1:0] tpl [N];
  logic [PIX_W-1:0] pix, diff;
  logic [2*PIX_W-1:0] dx;
  logic [ACC_W-1:0] acc, sum, bs;
  logic [XW-1:0] cx, bx;
  logic [YW-1:0] cy, by;
  logic [ADDR_W-1:0] ox, oy, row, col;
  logic ssd, et, dv, last_rd, cand_end, upd, last_cand, wrap, unused_hi;
  // Each phase (template load or one candidate) runs cnt = 0..N: reads issue while cnt < N and
  // the data of read cnt-1 arrives in the same cycle, so cnt == N is the last-data/compare cycle.
  always_comb begin
    unused_hi = ^mem_data;
    pix = mem_data[PIX_W-1:0];
    di = IW'(cnt - 1'b1);
    diff = tpl[di] > pix ? tpl[di] - pix : pix - tpl[di];
    dx = {{PIX_W{1'b0}}, diff};
    dv = state == SEARCH && cnt != '0;
    sum = acc + (dv ? (ssd ? ACC_W'(dx * dx) : ACC_W'(diff)) : '0);
    last_rd = cnt == CW'(N);
    // A candidate already at or above the best cannot win; the read issued this cycle is simply
    // ignored because the next candidate starts with cnt = 0, where incoming data is not accumulated.
    cand_end = state == SEARCH && (last_rd || (et && dv && sum >= bs));
    upd = state == SEARCH && last_rd && sum < bs;
    wrap = cx == XW'(SRCH_W - 1);
    last_cand = wrap && cy == YW'(SRCH_H - 1);
    row = oy + ADDR_W'(cy) + ADDR_W'(cnt / CW'(T_W));
    col = ox + ADDR_W'(cx) + ADDR_W'(cnt % CW'(T_W));
    busy = state == LOAD || state == SEARCH;
    done = state == DONE;
    mem_rd = busy && !last_rd;
    mem_addr = !mem_rd ? '0 : state == LOAD ? TPL_BASE + ADDR_W'(cnt) : IMG_BASE + row * ADDR_W'(IMG_W) + col;
    state_nx = abort ? IDLE :
               state == IDLE ? (start ? LOAD : IDLE) :
               state == LOAD ? (last_rd ? SEARCH : LOAD) :
               state == SEARCH ? (cand_end && last_cand ? DONE : SEARCH) : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (state == LOAD && cnt != '0) tpl[di] <= pix;
  // Working best (bx/by/bs) is kept apart from the outputs so results stay stable until the next match ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      acc <= '0;
      bs <= '0;
      cx <= '0;
      cy <= '0;
      bx <= '0;
      by <= '0;
      ox <= '0;
      oy <= '0;
      ssd <= 1'b0;
      et <= 1'b0;
      best_x <= '0;
      best_y <= '0;
      best_score <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
      acc <= '0;
      bs <= '1;
      cx <= '0;
      cy <= '0;
      bx <= '0;
      by <= '0;
      ox <= org_x;
      oy <= org_y;
      ssd <= mode_ssd;
      et <= early_term;
    end else if (state == LOAD) begin
      cnt <= last_rd ? '0 : cnt + 1'b1;
    end else if (state == SEARCH) begin
      cnt <= cand_end ? '0 : cnt + 1'b1;
      acc <= cand_end ? '0 : sum;
      if (upd) begin
        bs <= sum;
        bx <= cx;
        by <= cy;
      end
      if (cand_end) begin
        cx <= wrap ? '0 : cx + 1'b1;
        cy <= wrap ? cy + 1'b1 : cy;
      end
      if (cand_end && last_cand) begin
        best_x <= upd ? cx : bx;
        best_y <= upd ? cy : by;
        best_score <= upd ? sum : bs;
      end
    end
  end
endmodule

// File: tb/tb_template_match_sad.sv
// tb_template_match_sad: randomized self-checking bench for template_match_sad against a brute-force SAD/SSD model
module tb_template_match_sad;
  localparam int AW = 20;
  logic clk = 0, rst = 1, start = 0, start2 = 0, abort = 0, mode_ssd = 0, early_term = 0;
  logic [AW-1:0] org_x = '0, org_y = '0, mem_addr, mem_addr2;
  logic mem_rd, mem_rd2, busy, busy2, done, done2;
  logic [15:0] mem_data, mem_data2;
  logic [1:0] best_x, best_y, best_x2, best_y2;
  logic [19:0] best_score;
  logic [21:0] best_score2;
  logic [15:0] tmem [64];
  logic [15:0] fmem [256];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  template_match_sad #(.T_W(4), .T_H(4), .SRCH_W(4), .SRCH_H(4), .IMG_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_ssd(mode_ssd), .early_term(early_term),
    .org_x(org_x), .org_y(org_y), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .busy(busy), .done(done), .best_x(best_x), .best_y(best_y), .best_score(best_score));
  template_match_sad #(.SRCH_W(4), .SRCH_H(4), .IMG_W(16)) u_sat (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .mode_ssd(mode_ssd), .early_term(early_term),
    .org_x(org_x), .org_y(org_y), .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_data(mem_data2),
    .busy(busy2), .done(done2), .best_x(best_x2), .best_y(best_y2), .best_score(best_score2));
  function automatic logic [15:0] rdmem(input logic [AW-1:0] a);
    if (a < 64) return tmem[a[5:0]];
    if (a >= 20'h10000 && a < 20'h10100) return fmem[a[7:0]];
    return 16'hdead;
  endfunction
  always @(posedge clk) begin
    mem_data <= mem_rd ? rdmem(mem_addr) : 16'($urandom);
    mem_data2 <= mem_rd2 ? rdmem(mem_addr2) : 16'($urandom);
  end
  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int tpx(input int i);
    return int'(tmem[i][7:0]);
  endfunction
  function automatic int fpx(input int r, input int c);
    return int'(fmem[r * 16 + c][7:0]);
  endfunction
  task automatic model(input bit ssd, input int ox, input int oy, output int bx, output int by, output longint bs);
    bs = 64'h7fff_ffff_ffff_ffff;
    bx = 0;
    by = 0;
    for (int cy = 0; cy < 4; cy++)
      for (int cx = 0; cx < 4; cx++) begin
        longint s = 0;
        for (int ty = 0; ty < 4; ty++)
          for (int tx = 0; tx < 4; tx++) begin
            longint d = longint'(tpx(ty * 4 + tx) - fpx(oy + cy + ty, ox + cx + tx));
            if (d < 0) d = -d;
            s += ssd ? d * d : d;
          end
        if (s < bs) begin
          bs = s;
          bx = cx;
          by = cy;
        end
      end
  endtask
  task automatic check_model(input string tag, input bit ssd, input int ox, input int oy, output longint bs);
    int bx, by;
    model(ssd, ox, oy, bx, by, bs);
    check({tag, "_x"}, best_x, bx);
    check({tag, "_y"}, best_y, by);
    check({tag, "_score"}, best_score, bs);
  endtask
  task automatic rand_mem();
    foreach (tmem[i]) tmem[i] = 16'($urandom);
    foreach (fmem[i]) fmem[i] = 16'($urandom);
  endtask
  task automatic tpl_from(input int x, input int y, input int noise);
    for (int i = 0; i < 16; i++)
      tmem[i] = {8'($urandom), 8'(fpx(y + i / 4, x + i % 4) ^ int'($urandom_range(0, noise)))};
  endtask
  task automatic run(input bit ssd, input bit et, input int ox, input int oy, output int lat, output int rds);
    @(negedge clk);
    mode_ssd = ssd;
    early_term = et;
    org_x = AW'(ox);
    org_y = AW'(oy);
    start = 1;
    lat = 0;
    rds = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 0;
      rds += int'(mem_rd);
      if (lat == 1) check("busy_rd_rise", {busy, mem_rd}, 2'b11);
    end while (!done && lat < 5000);
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_pulse_busy", {done, busy}, 0);
  endtask
  initial begin
    int lat, rds, rds0, nd, ox, oy;
    bit ssd, et;
    longint ebs, prev;
    #2 rst = 0;
    #1;
    check("rst_addr", mem_addr, 0);
    check("rst_rd_busy_done", {mem_rd, busy, done}, 0);
    check("rst_best", {best_x, best_y, best_score}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    rand_mem();
    tpl_from(2, 1, 0);
    run(0, 0, 0, 0, lat, rds);
    check("exact_latency", lat, 290);
    check("exact_reads", rds, 272);
    check("exact_x", best_x, 2);
    check("exact_y", best_y, 1);
    check("exact_score", best_score, 0);
    rand_mem();
    for (int r = 2; r < 6; r++)
      for (int c = 3; c < 7; c++) fmem[r * 16 + c] = fmem[(r - 2) * 16 + c - 2];
    tpl_from(1, 0, 0);
    run(0, 0, 0, 0, lat, rds);
    check("tie_x", best_x, 1);
    check("tie_y", best_y, 0);
    check("tie_score", best_score, 0);
    repeat (4) begin
      rand_mem();
      ox = int'($urandom_range(0, 9));
      oy = int'($urandom_range(0, 9));
      ssd = 1'($urandom);
      et = 1'($urandom);
      run(ssd, et, ox, oy, lat, rds);
      check_model("rand", ssd, ox, oy, ebs);
    end
    rand_mem();
    tpl_from(0, 0, 3);
    run(1, 0, 0, 0, lat, rds0);
    check_model("ssd_full", 1, 0, 0, ebs);
    run(1, 1, 0, 0, lat, rds);
    check_model("ssd_et", 1, 0, 0, ebs);
    check("et_fewer_reads", rds < rds0, 1);
    prev = ebs;
    @(negedge clk);
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    check("start_abort_idle", busy, 0);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (49) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("abort_busy", busy, 0);
    check("abort_rd", mem_rd, 0);
    nd = 0;
    repeat (400) begin
      @(negedge clk);
      nd += int'(done);
    end
    check("abort_no_done", nd, 0);
    check("abort_best_kept", best_score, prev);
    rand_mem();
    tpl_from(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 7);
    run(0, 1, 0, 0, lat, rds);
    check_model("after_abort", 0, 0, 0, ebs);
    rand_mem();
    tpl_from(3, 3, 0);
    @(negedge clk);
    mode_ssd = 0;
    early_term = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (100) @(negedge clk);
    #2 rst = 0;
    #1;
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_ctl", {mem_rd, busy, done}, 0);
    check("mid_rst_best", {best_x, best_y, best_score}, 0);
    start = 1;
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      nd += int'(busy);
    end
    check("rst_start_ignored", nd, 0);
    start = 0;
    rst = 1;
    @(negedge clk);
    check("rst_release_idle", busy, 0);
    run(0, 0, 0, 0, lat, rds);
    check("after_rst_x", best_x, 3);
    check("after_rst_y", best_y, 3);
    check("after_rst_score", best_score, 0);
    foreach (tmem[i]) tmem[i] = {8'($urandom), 8'hff};
    foreach (fmem[i]) fmem[i] = {8'($urandom), 8'h00};
    @(negedge clk);
    mode_ssd = 1;
    early_term = 0;
    org_x = '0;
    org_y = '0;
    start2 = 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start2 = 0;
    end while (!done2 && lat < 5000);
    check("sat_latency", lat, 1106);
    check("sat_score", best_score2, 4161600);
    check("sat_xy", {best_x2, best_y2}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
